// File: rtl/fetch_stage_ctrl.sv
// Fetch stage of the pipelined MIPS core: PC register, IF/ID register, imem request FSM
// and a one-entry skid buffer for instructions that return while decode is stalled.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pc_branchD,
  input  logic        jumpD,
  input  logic [31:0] pc_jumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus4D,
  output logic        validD
);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_r;
  logic        buf_valid_r;
  logic [31:0] pend_pc_r;
  logic [31:0] instr_d_r;
  logic [31:0] pc_plus4_d_r;
  logic        valid_d_r;

  logic        hold_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  // Hazard/redirect decode; a redirect seen under stallD is re-presented by decode later.
  always_comb begin
    hold_s     = stallF | stallD;
    redirect_s = (pcsrcD | jumpD) & ~stallD;
    pc_inc_s   = pc_r + 32'd4;
    if (jumpD) begin
      target_s = pc_jumpD;
    end else begin
      target_s = pc_branchD;
    end
  end

  // PC, IF/ID, skid buffer and request FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      buf_r        <= 32'h0000_0000;
      buf_valid_r  <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
      instr_d_r    <= 32'h0000_0000;
      pc_plus4_d_r <= 32'h0000_0000;
      valid_d_r    <= 1'b0;
    end else if (redirect_s) begin
      instr_d_r   <= 32'h0000_0000;
      valid_d_r   <= 1'b0;
      buf_valid_r <= 1'b0;
      // An outstanding request must complete at its old address before the PC may move.
      if (imem_ready || buf_valid_r) begin
        pc_r    <= target_s;
        state_r <= ST_REQ;
      end else begin
        pend_pc_r <= target_s;
        state_r   <= ST_KILL;
      end
    end else begin
      case (state_r)
        ST_KILL: begin
          if (imem_ready) begin
            pc_r    <= pend_pc_r;
            state_r <= ST_REQ;
          end
          if (!hold_s) begin
            instr_d_r <= 32'h0000_0000;
            valid_d_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (buf_valid_r) begin
            if (!hold_s) begin
              instr_d_r    <= buf_r;
              pc_plus4_d_r <= pc_inc_s;
              valid_d_r    <= 1'b1;
              pc_r         <= pc_inc_s;
              buf_valid_r  <= 1'b0;
            end
          end else if (imem_ready) begin
            if (!hold_s) begin
              instr_d_r    <= imem_rdata;
              pc_plus4_d_r <= pc_inc_s;
              valid_d_r    <= 1'b1;
              pc_r         <= pc_inc_s;
            end else begin
              buf_r       <= imem_rdata;
              buf_valid_r <= 1'b1;
            end
          end else if (!hold_s) begin
            instr_d_r <= 32'h0000_0000;
            valid_d_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_REQ;
        end
      endcase
    end
  end

  assign imem_req  = ~rst & ~buf_valid_r;
  assign imem_addr = pc_r;
  assign pcF       = pc_r;
  assign instrD    = instr_d_r;
  assign pc_plus4D = pc_plus4_d_r;
  assign validD    = valid_d_r;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: directed per-cycle stimulus pushes expected outputs,
// a negedge monitor pops and compares them. A second instance covers PC wrap-around.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, pcsrcD, jumpD, imem_ready;
  logic [31:0] pc_branchD, pc_jumpD, imem_rdata;

  logic        req1, req2, v1, v2;
  logic [31:0] addr1, addr2, pc1, pc2, ins1, ins2, p41, p42;

  always #5 clk = ~clk;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000)) u1 (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .pcsrcD(pcsrcD),
    .pc_branchD(pc_branchD), .jumpD(jumpD), .pc_jumpD(pc_jumpD),
    .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pcF(pc1), .instrD(ins1), .pc_plus4D(p41), .validD(v1)
  );

  fetch_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u2 (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .pcsrcD(pcsrcD),
    .pc_branchD(pc_branchD), .jumpD(jumpD), .pc_jumpD(pc_jumpD),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pcF(pc2), .instrD(ins2), .pc_plus4D(p42), .validD(v2)
  );

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic        req;
    logic        v;
    logic [31:0] ins;
    logic [31:0] p4;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL cycle %0d %s: got %h expected %h", tag, nm, act, exp_v);
    end
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.sel) begin
        chk(e.tag, "u1.pcF", pc1, e.pc);
        chk(e.tag, "u1.imem_addr", addr1, e.pc);
        chk(e.tag, "u1.imem_req", {31'd0, req1}, {31'd0, e.req});
        chk(e.tag, "u1.validD", {31'd0, v1}, {31'd0, e.v});
        chk(e.tag, "u1.instrD", ins1, e.ins);
        chk(e.tag, "u1.pc_plus4D", p41, e.p4);
      end else begin
        chk(e.tag, "u2.pcF", pc2, e.pc);
        chk(e.tag, "u2.imem_addr", addr2, e.pc);
        chk(e.tag, "u2.imem_req", {31'd0, req2}, {31'd0, e.req});
        chk(e.tag, "u2.validD", {31'd0, v2}, {31'd0, e.v});
        chk(e.tag, "u2.instrD", ins2, e.ins);
        chk(e.tag, "u2.pc_plus4D", p42, e.p4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic r, input logic sf, input logic sd, input logic br,
                       input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                       input logic rdy, input logic [31:0] rd);
    rst = r; stallF = sf; stallD = sd; pcsrcD = br; pc_branchD = bt;
    jumpD = jp; pc_jumpD = jt; imem_ready = rdy; imem_rdata = rd;
  endtask

  task automatic ex(input bit sel, input logic [31:0] pc, input logic req, input logic v,
                    input logic [31:0] ins, input logic [31:0] p4);
    exp_t e;
    e.sel = sel; e.pc = pc; e.req = req; e.v = v; e.ins = ins; e.p4 = p4; e.tag = cyc;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); ex(0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    // T1: zero-wait memory, rdata = address
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0);  ex(0, 32'h0,  1, 0, 32'h0, 32'h0);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4);  ex(0, 32'h4,  1, 1, 32'h0, 32'h4);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8);  ex(0, 32'h8,  1, 1, 32'h4, 32'h8);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hC);  ex(0, 32'hC,  1, 1, 32'h8, 32'hC);
    // T2: three-cycle fetch latency
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);  ex(0, 32'h10, 1, 1, 32'hC, 32'h10);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);  ex(0, 32'h10, 1, 0, 32'h0, 32'h10);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h10); ex(0, 32'h10, 1, 0, 32'h0, 32'h10);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);  ex(0, 32'h14, 1, 1, 32'h10, 32'h14);
    // T3: instruction returns under stall and is held in the skid buffer
    tick(); drive(0, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'hAAAA_0001); ex(0, 32'h14, 1, 0, 32'h0, 32'h14);
    tick(); drive(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);  ex(0, 32'h14, 0, 0, 32'h0, 32'h14);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);  ex(0, 32'h14, 0, 0, 32'h0, 32'h14);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);  ex(0, 32'h18, 1, 1, 32'hAAAA_0001, 32'h18);
    // T4: branch while a fetch is pending -> KILL, orphaned word dropped
    tick(); drive(0, 0, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0); ex(0, 32'h18, 1, 0, 32'h0, 32'h18);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);   ex(0, 32'h18, 1, 0, 32'h0, 32'h18);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hDEAD_BEEF); ex(0, 32'h18, 1, 0, 32'h0, 32'h18);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h1234_5678); ex(0, 32'h100, 1, 0, 32'h0, 32'h18);
    // T5: jump wins over branch; then the same under stallD is ignored
    tick(); drive(0, 0, 0, 1, 32'h300, 1, 32'h200, 1, 32'h5555_5555); ex(0, 32'h104, 1, 1, 32'h1234_5678, 32'h104);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h200);  ex(0, 32'h200, 1, 0, 32'h0, 32'h104);
    tick(); drive(0, 0, 1, 1, 32'h300, 1, 32'h400, 1, 32'h204); ex(0, 32'h204, 1, 1, 32'h200, 32'h204);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);    ex(0, 32'h204, 0, 1, 32'h200, 32'h204);
    // T6: reset asserted while in KILL, plus PC wrap on the second instance
    tick(); drive(0, 0, 0, 1, 32'h300, 0, 32'h0, 0, 32'h0);  ex(0, 32'h208, 1, 1, 32'h204, 32'h208);
    tick(); drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);    ex(0, 32'h208, 0, 0, 32'h0, 32'h208);
    tick(); drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ex(0, 32'h0, 0, 0, 32'h0, 32'h0);
    ex(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h1111_0000);
    ex(0, 32'h0, 1, 0, 32'h0, 32'h0);
    ex(1, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h0);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h2222_0000);
    ex(0, 32'h4, 1, 1, 32'h1111_0000, 32'h4);
    ex(1, 32'h0, 1, 1, 32'h1111_0000, 32'h0);
    tick(); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    ex(0, 32'h8, 1, 1, 32'h2222_0000, 32'h8);
    ex(1, 32'h4, 1, 1, 32'h2222_0000, 32'h4);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
